// File: rtl/acoustic_stream_pkg.sv
// Shared defaults and types for the acoustic frame streamer.
// Build option: AXIS_TLAST_EN adds the T_LAST output and a frame beat counter.
package acoustic_stream_pkg;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_DEPTH       = 256;
    localparam int DEF_ADDR_W      = $clog2(DEF_DEPTH);
    localparam int DEF_CAPTURE_DLY = 4;
    localparam int DEF_FRAME_WORDS = 64;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } cap_state_t;
endpackage

// File: rtl/acoustic_frame_streamer_axis_master.sv
// Delayed capture of the ring output onto a single-beat AXI-Stream register.
// Build option: AXIS_TLAST_EN marks every FRAME_WORDS-th accepted beat with T_LAST.
module axis_master
    import acoustic_stream_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
`ifdef AXIS_TLAST_EN
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
`endif
    parameter int CAPTURE_DLY = DEF_CAPTURE_DLY
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              fourth_pulse,
    input  logic              send_frame,
    input  logic [DATA_W-1:0] ring_data,
    input  logic              T_READY,
    output logic              T_VALID,
`ifdef AXIS_TLAST_EN
    output logic              T_LAST,
`endif
    output logic [DATA_W-1:0] T_DATA
);
    // Handshake: a beat transfers on a clk edge with T_VALID & T_READY; while
    // T_VALID & !T_READY the beat is pending, T_DATA holds and new captures drop.
    localparam int CW = $clog2(CAPTURE_DLY + 1);

    cap_state_t        state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              capture, pending;
    logic              t_valid_nx;
    logic [DATA_W-1:0] t_data_nx;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            T_VALID <= 1'b0;
            T_DATA  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            T_VALID <= t_valid_nx;
            T_DATA  <= t_data_nx;
        end
    end

    // A new fourth-sample edge restarts the delay count.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (fourth_pulse && send_frame) begin
            state_nx = ST_COUNT;
            cnt_nx   = CW'(CAPTURE_DLY - 1);
        end else if (state == ST_COUNT) begin
            if (cnt == CW'(1)) state_nx = ST_IDLE;
            cnt_nx = cnt - 1'b1;
        end
    end

    always_comb begin
        capture    = (state == ST_COUNT) && (cnt == CW'(1));
        pending    = T_VALID && !T_READY;
        t_valid_nx = T_VALID;
        t_data_nx  = T_DATA;
        if (T_VALID && T_READY) t_valid_nx = 1'b0;
        if (capture && !pending) begin
            t_valid_nx = 1'b1;
            t_data_nx  = ring_data;
        end
    end

`ifdef AXIS_TLAST_EN
    localparam int BW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(FRAME_WORDS - 1);
    logic [BW-1:0] beat_cnt;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            beat_cnt <= '0;
        end else if (T_VALID && T_READY) begin
            beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;
        end
    end

    assign T_LAST = T_VALID && (beat_cnt == BEAT_LAST);
`endif
endmodule

// File: rtl/acoustic_frame_streamer_ring_buffer.sv
// Circular sample-history RAM: read-before-write per sample, so Output_Data
// carries the sample written DEPTH writes earlier once the ring is primed.
module ring_buffer
    import acoustic_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] Output_Data,
    output logic              Send_Frame,
    output logic              RAM_Overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FILL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   FILL_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       fill;

    // Sample storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr       <= '0;
            fill         <= '0;
            Output_Data  <= '0;
            Send_Frame   <= 1'b0;
            RAM_Overflow <= 1'b0;
        end else begin
            RAM_Overflow <= wr_en && (wr_ptr == PTR_LAST);
            if (wr_en) begin
                Output_Data <= mem[wr_ptr];
                wr_ptr      <= wr_ptr + 1'b1;
                if (fill != FILL_FULL) fill <= fill + 1'b1;
                if (fill == FILL_LAST) Send_Frame <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/acoustic_frame_streamer.sv
// Top: rising-edge detectors for the sample strobes, ring delay line, stream master.
// Build option: AXIS_TLAST_EN adds the T_LAST output.
module acoustic_frame_streamer
    import acoustic_stream_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
`ifdef AXIS_TLAST_EN
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
`endif
    parameter int CAPTURE_DLY = DEF_CAPTURE_DLY
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [DATA_W-1:0] Input_Data,
    input  logic              Input_Data_Ready,
    input  logic              Fourth_Sample_Ready,
    input  logic              T_READY,
    output logic              Send_Frame,
    output logic              RAM_Overflow,
    output logic              T_VALID,
`ifdef AXIS_TLAST_EN
    output logic              T_LAST,
`endif
    output logic [DATA_W-1:0] T_DATA
);
    logic              idr_q, wr_pulse;
    logic              fsr_q, fourth_pulse;
    logic [DATA_W-1:0] ring_data;

    // Registered edge pulses: a long strobe level yields exactly one write.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            idr_q        <= 1'b0;
            wr_pulse     <= 1'b0;
            fsr_q        <= 1'b0;
            fourth_pulse <= 1'b0;
        end else begin
            idr_q        <= Input_Data_Ready;
            wr_pulse     <= Input_Data_Ready && !idr_q;
            fsr_q        <= Fourth_Sample_Ready;
            fourth_pulse <= Fourth_Sample_Ready && !fsr_q;
        end
    end

    ring_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ring (
        .clk          (clk),
        .reset_b      (reset_b),
        .wr_en        (wr_pulse),
        .wr_data      (Input_Data),
        .Output_Data  (ring_data),
        .Send_Frame   (Send_Frame),
        .RAM_Overflow (RAM_Overflow)
    );

    axis_master #(
        .DATA_W      (DATA_W),
`ifdef AXIS_TLAST_EN
        .FRAME_WORDS (FRAME_WORDS),
`endif
        .CAPTURE_DLY (CAPTURE_DLY)
    ) u_axis (
        .clk          (clk),
        .reset_b      (reset_b),
        .fourth_pulse (fourth_pulse),
        .send_frame   (Send_Frame),
        .ring_data    (ring_data),
        .T_READY      (T_READY),
        .T_VALID      (T_VALID),
`ifdef AXIS_TLAST_EN
        .T_LAST       (T_LAST),
`endif
        .T_DATA       (T_DATA)
    );
endmodule

// File: tb/tb_acoustic_frame_streamer.sv
// Directed bench for acoustic_frame_streamer with a history model and beat scoreboard.
// Build option: AXIS_TLAST_EN also checks T_LAST with FRAME_WORDS=4.
module tb_acoustic_frame_streamer;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset_b;
    logic [DATA_W-1:0] Input_Data;
    logic              Input_Data_Ready;
    logic              Fourth_Sample_Ready;
    logic              T_READY;
    logic              Send_Frame;
    logic              RAM_Overflow;
    logic              T_VALID;
    logic [DATA_W-1:0] T_DATA;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                model_ptr  = 0;
    int                model_fill = 0;
    int                exp_ovf    = 0;
    int                ovf_cnt    = 0;
    int                vcyc       = 0;
    logic [DATA_W-1:0] last_exp   = '0;
    logic              prev_pend  = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;

    always #5 clk = ~clk;

`ifdef AXIS_TLAST_EN
    logic T_LAST;
    int   tb_beats = 0;
    acoustic_frame_streamer #(.FRAME_WORDS(4)) dut (
        .clk                 (clk),
        .reset_b             (reset_b),
        .Input_Data          (Input_Data),
        .Input_Data_Ready    (Input_Data_Ready),
        .Fourth_Sample_Ready (Fourth_Sample_Ready),
        .T_READY             (T_READY),
        .Send_Frame          (Send_Frame),
        .RAM_Overflow        (RAM_Overflow),
        .T_VALID             (T_VALID),
        .T_LAST              (T_LAST),
        .T_DATA              (T_DATA)
    );
`else
    acoustic_frame_streamer dut (
        .clk                 (clk),
        .reset_b             (reset_b),
        .Input_Data          (Input_Data),
        .Input_Data_Ready    (Input_Data_Ready),
        .Fourth_Sample_Ready (Fourth_Sample_Ready),
        .T_READY             (T_READY),
        .Send_Frame          (Send_Frame),
        .RAM_Overflow        (RAM_Overflow),
        .T_VALID             (T_VALID),
        .T_DATA              (T_DATA)
    );
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one sample; the model predicts the captured history word, if any.
    task automatic write_sample(input logic [DATA_W-1:0] val, input bit fourth,
                                input int hi, input bit dropped);
        if (fourth && model_fill == DEPTH && !dropped) begin
            exp_q.push_back(model_mem[model_ptr]);
            last_exp = model_mem[model_ptr];
        end
        model_mem[model_ptr] = val;
        model_ptr = (model_ptr + 1) % DEPTH;
        if (model_ptr == 0) exp_ovf++;
        if (model_fill < DEPTH) model_fill++;
        Input_Data          = val;
        Input_Data_Ready    = 1'b1;
        Fourth_Sample_Ready = fourth;
        repeat (hi) @(posedge clk);
        #1;
        Input_Data_Ready    = 1'b0;
        Fourth_Sample_Ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Monitor: beat scoreboard, pending-beat stability, pulse/valid counters.
    always @(negedge clk) begin
        if (!reset_b) begin
            prev_pend = 1'b0;
`ifdef AXIS_TLAST_EN
            tb_beats = 0;
`endif
        end else begin
            if (prev_pend) begin
                check("hold_valid", 64'(T_VALID), 64'd1);
                check("hold_data", 64'(T_DATA), 64'(prev_data));
            end
            if (T_VALID) vcyc++;
            if (RAM_Overflow) ovf_cnt++;
            if (T_VALID && T_READY) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("beat_data", 64'(T_DATA), 64'(exp_q.pop_front()));
`ifdef AXIS_TLAST_EN
                check("t_last", 64'(T_LAST), 64'((tb_beats % 4) == 3));
                tb_beats++;
`endif
            end
            prev_pend = T_VALID && !T_READY;
            prev_data = T_DATA;
        end
    end

    initial begin
        int v0;
        reset_b             = 1'b0;
        Input_Data          = '0;
        Input_Data_Ready    = 1'b0;
        Fourth_Sample_Ready = 1'b0;
        T_READY             = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_send_frame", 64'(Send_Frame), 64'd0);
        check("rst_overflow", 64'(RAM_Overflow), 64'd0);
        check("rst_t_valid", 64'(T_VALID), 64'd0);
        check("rst_t_data", 64'(T_DATA), 64'd0);
        reset_b = 1'b1;
        @(posedge clk);
        #1;

        // Priming: 255 writes keep the stream silent.
        for (int i = 0; i < 255; i++) write_sample(DATA_W'(i), (i % 4) == 0, 3, 1'b0);
        check("prime_send_frame_low", 64'(Send_Frame), 64'd0);
        check("prime_no_valid", 64'(vcyc), 64'd0);
        check("prime_no_overflow", 64'(ovf_cnt), 64'(exp_ovf));
        write_sample(DATA_W'(255), 1'b0, 3, 1'b0);
        check("primed_send_frame", 64'(Send_Frame), 64'd1);
        check("first_wrap_overflow", 64'(ovf_cnt), 64'd1);

        // Streaming: every 4th sample emits the word written 256 samples earlier.
        v0 = vcyc;
        for (int i = 256; i < 512; i++) write_sample(DATA_W'(i), (i % 4) == 0, 3, 1'b0);
        check("stream_valid_cycles", 64'(vcyc - v0), 64'd64);
        check("stream_queue_empty", 64'(exp_q.size()), 64'd0);
        check("second_wrap_overflow", 64'(ovf_cnt), 64'(exp_ovf));

        // Long strobe level: one write only, so history alignment stays intact.
        write_sample(32'h0000_1000, 1'b0, 14, 1'b0);
        for (int j = 0; j < 8; j++) write_sample(DATA_W'(32'h2000 + j), (j % 4) == 3, 3, 1'b0);
        check("held_strobe_queue", 64'(exp_q.size()), 64'd0);

        // Backpressure: first beat held, second capture dropped.
        T_READY = 1'b0;
        write_sample(DATA_W'(32'h3000), 1'b1, 3, 1'b0);
        check("bp_valid_up", 64'(T_VALID), 64'd1);
        check("bp_first_data", 64'(T_DATA), 64'(last_exp));
        for (int j = 1; j < 4; j++) write_sample(DATA_W'(32'h3000 + j), 1'b0, 3, 1'b0);
        write_sample(DATA_W'(32'h3004), 1'b1, 3, 1'b1);
        repeat (400 - 5 * 9) @(posedge clk);
        #1;
        check("bp_still_first", 64'(T_DATA), 64'(last_exp));
        T_READY = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_valid_falls", 64'(T_VALID), 64'd0);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset while a beat is pending.
        T_READY = 1'b0;
        for (int j = 0; j < 3; j++) write_sample(DATA_W'(32'h4000 + j), 1'b0, 3, 1'b0);
        write_sample(DATA_W'(32'h4003), 1'b1, 3, 1'b0);
        check("mid_valid_up", 64'(T_VALID), 64'd1);
        #3;
        reset_b = 1'b0;
        #1;
        check("async_t_valid", 64'(T_VALID), 64'd0);
        check("async_send_frame", 64'(Send_Frame), 64'd0);
        check("async_overflow", 64'(RAM_Overflow), 64'd0);
        check("async_t_data", 64'(T_DATA), 64'd0);
        exp_q.delete();
        model_ptr  = 0;
        model_fill = 0;
        ovf_cnt    = 0;
        exp_ovf    = 0;
        @(posedge clk);
        #1;
        reset_b = 1'b1;
        T_READY = 1'b1;
        @(posedge clk);
        #1;

        // Re-prime with random data and strobe widths.
        v0 = vcyc;
        for (int i = 0; i < 255; i++)
            write_sample(DATA_W'($urandom_range(0, 65535)), (i % 4) == 0, $urandom_range(2, 4), 1'b0);
        check("reprime_send_frame_low", 64'(Send_Frame), 64'd0);
        check("reprime_no_valid", 64'(vcyc - v0), 64'd0);
        write_sample(DATA_W'($urandom_range(0, 65535)), 1'b0, 3, 1'b0);
        check("reprime_send_frame", 64'(Send_Frame), 64'd1);
        check("reprime_overflow", 64'(ovf_cnt), 64'(exp_ovf));
        for (int j = 0; j < 16; j++) write_sample(DATA_W'($urandom_range(0, 65535)), (j % 4) == 0, 3, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
